fir_coeff_loader: RTL and testbench



---
 rtl/fir_pkg.sv | 22 ++
 rtl/fir_coeff_loader_grant_timer.sv | 32 +++
 rtl/fir_coeff_loader.sv | 126 ++++++++++++
 tb/tb_fir_coeff_loader.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR datapath: opcodes, register index width, loader states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fir_pkg;

  localparam int REG_IDX_W = 4;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_COPY  = 3'd1;
  localparam logic [2:0] OP_LOAD1 = 3'd2;
  localparam logic [2:0] OP_LOAD2 = 3'd3;
  localparam logic [2:0] OP_ADD   = 3'd4;
  localparam logic [2:0] OP_SUB   = 3'd5;
  localparam logic [2:0] OP_MUL   = 3'd6;

  typedef enum logic [1:0] {
    LD_IDLE  = 2'd0,
    LD_REQ   = 2'd1,
    LD_ISSUE = 2'd2
  } ld_state_t;

endpackage

// File: rtl/fir_coeff_loader_grant_timer.sv
// Loadable down-counter bounding how long the loader waits for a datapath grant.
// Latency: expire asserts combinationally in the LOAD_VAL-th enabled cycle after load.
// Backpressure: none; counts only while en is high.
// Ports: clk, rst (sync, active-high), load (reload to LOAD_VAL), en (count this cycle),
//        expire (final enabled cycle of the window).
module grant_timer #(
  parameter int WIDTH    = 8,
  parameter int LOAD_VAL = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expire
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= WIDTH'(LOAD_VAL);
    end else if (en && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  // Remaining count of one while enabled means this is the last cycle of the window.
  assign expire = en && (count == WIDTH'(1));

endmodule

// File: rtl/fir_coeff_loader.sv
// Sequences coefficient writes into the FIR register file as single LOAD2 micro-ops.
// Latency: accept at N, dp_req at N+1, ISSUE one cycle after grant is sampled, ready again the cycle after ISSUE.
// Backpressure: coeff_ready is high only in IDLE; one write is in flight at a time.
// Ports: coeff_valid/coeff_ready/coeff_data/coeff_index write handshake; clear_coeffs wipes
//        loaded flags and err; dp_req/dp_gnt datapath ownership; op/dest/ext_coeff datapath
//        drive; coeff_loaded/all_loaded slot status; err sticky timeout / bad-index flag.
// Optional: define COEFF_SHADOW_EN to skip rewriting a loaded slot with an identical value.
module fir_coeff_loader
  import fir_pkg::*;
#(
  parameter int                   NUM_COEFF      = 4,
  parameter logic [REG_IDX_W-1:0] COEFF_BASE_REG = 4'd6,
  parameter int                   GNT_TIMEOUT    = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         coeff_valid,
  output logic                         coeff_ready,
  input  logic [15:0]                  coeff_data,
  input  logic [$clog2(NUM_COEFF)-1:0] coeff_index,
  input  logic                         clear_coeffs,
  output logic                         dp_req,
  input  logic                         dp_gnt,
  output logic [2:0]                   op,
  output logic [REG_IDX_W-1:0]         dest,
  output logic [15:0]                  ext_coeff,
  output logic [NUM_COEFF-1:0]         coeff_loaded,
  output logic                         all_loaded,
  output logic                         err
);

  localparam int               IDX_W = $clog2(NUM_COEFF);
  localparam int               TMR_W = $clog2(GNT_TIMEOUT + 1);
  localparam logic [IDX_W:0]   NUM_C = (IDX_W + 1)'(NUM_COEFF);

  ld_state_t        state;
  logic [15:0]      data_q;
  logic [IDX_W-1:0] idx_q;
  logic             accept;
  logic             idx_bad;
  logic             shadow_hit;
  logic             tmr_expire;
  logic             timed_out;

  // Ready is held low while rst is asserted so nothing is accepted in the reset cycle.
  assign coeff_ready = (state == LD_IDLE) && !rst;
  assign accept      = coeff_valid && coeff_ready;
  // Only reachable when NUM_COEFF is not a power of two.
  assign idx_bad     = {1'b0, coeff_index} >= NUM_C;

`ifdef COEFF_SHADOW_EN
  logic [15:0] shadow [NUM_COEFF];

  assign shadow_hit = !idx_bad && coeff_loaded[coeff_index] && (shadow[coeff_index] == coeff_data);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_COEFF; i++) shadow[i] <= '0;
    end else if (state == LD_ISSUE) begin
      shadow[idx_q] <= data_q;
    end
  end
`else
  assign shadow_hit = 1'b0;
`endif

  // Reloading on every accept is harmless for writes that never enter REQ.
  grant_timer #(
    .WIDTH    (TMR_W),
    .LOAD_VAL (GNT_TIMEOUT)
  ) u_grant_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (accept),
    .en     (state == LD_REQ),
    .expire (tmr_expire)
  );

  // A grant seen in the final window cycle still wins over the timeout.
  assign timed_out = (state == LD_REQ) && !dp_gnt && tmr_expire;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= LD_IDLE;
      data_q <= '0;
      idx_q  <= '0;
    end else begin
      case (state)
        LD_IDLE: begin
          if (accept) begin
            data_q <= coeff_data;
            idx_q  <= coeff_index;
            if (!idx_bad && !shadow_hit) state <= LD_REQ;
          end
        end
        LD_REQ: begin
          if (dp_gnt)         state <= LD_ISSUE;
          else if (timed_out) state <= LD_IDLE;
        end
        LD_ISSUE: state <= LD_IDLE;
        default:  state <= LD_IDLE;
      endcase
    end
  end

  // Clear beats any same-cycle set of a loaded flag or err.
  always_ff @(posedge clk) begin
    if (rst) begin
      coeff_loaded <= '0;
      err          <= 1'b0;
    end else if (clear_coeffs) begin
      coeff_loaded <= '0;
      err          <= 1'b0;
    end else begin
      if (state == LD_ISSUE)                 coeff_loaded[idx_q] <= 1'b1;
      if ((accept && idx_bad) || timed_out) err                 <= 1'b1;
    end
  end

  assign dp_req     = (state == LD_REQ) || (state == LD_ISSUE);
  assign op         = (state == LD_ISSUE) ? OP_LOAD2 : OP_NOP;
  assign dest       = (state == LD_ISSUE) ? (COEFF_BASE_REG + REG_IDX_W'(idx_q)) : '0;
  assign ext_coeff  = data_q;
  assign all_loaded = &coeff_loaded;

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Self-checking bench for fir_coeff_loader: directed cases then randomized writes vs a transaction model.
// Latency: n/a.
// Backpressure: n/a.
module tb_fir_coeff_loader;
  import fir_pkg::*;

  localparam int NC = 4;
  localparam int GT = 8;
  localparam int BASE = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        coeff_valid;
  logic        coeff_ready;
  logic [15:0] coeff_data;
  logic [1:0]  coeff_index;
  logic        clear_coeffs;
  logic        dp_req;
  logic        dp_gnt;
  logic [2:0]  op;
  logic [3:0]  dest;
  logic [15:0] ext_coeff;
  logic [3:0]  coeff_loaded;
  logic        all_loaded;
  logic        err;

  int tests = 0;
  int fails = 0;

  // Transaction-level model state
  logic [3:0]  m_loaded = 4'b0;
  logic        m_err    = 1'b0;
  logic [15:0] m_shadow [NC];
  logic [15:0] m_last   = 16'h0;

  fir_coeff_loader #(
    .NUM_COEFF      (NC),
    .COEFF_BASE_REG (4'd6),
    .GNT_TIMEOUT    (GT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .coeff_valid  (coeff_valid),
    .coeff_ready  (coeff_ready),
    .coeff_data   (coeff_data),
    .coeff_index  (coeff_index),
    .clear_coeffs (clear_coeffs),
    .dp_req       (dp_req),
    .dp_gnt       (dp_gnt),
    .op           (op),
    .dest         (dest),
    .ext_coeff    (ext_coeff),
    .coeff_loaded (coeff_loaded),
    .all_loaded   (all_loaded),
    .err          (err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_ready"},  coeff_ready,  1);
    chk({tag, "_dp_req"}, dp_req,       0);
    chk({tag, "_op"},     op,           OP_NOP);
    chk({tag, "_dest"},   dest,         0);
    chk({tag, "_ext"},    ext_coeff,    m_last);
    chk({tag, "_loaded"}, coeff_loaded, m_loaded);
    chk({tag, "_all"},    all_loaded,   &m_loaded);
    chk({tag, "_err"},    err,          m_err);
  endtask

  task automatic do_clear();
    clear_coeffs = 1'b1;
    tick();
    clear_coeffs = 1'b0;
    m_loaded = '0;
    m_err    = 1'b0;
    check_idle("clear");
  endtask

  // d = number of REQ cycles in which the grant is still low; d >= GT means timeout.
  task automatic do_write(input int idx, input logic [15:0] data, input int d,
                          input bit clr_req, input bit clr_iss, input bit drop_gnt);
    bit hit;
    hit = 1'b0;
`ifdef COEFF_SHADOW_EN
    hit = m_loaded[idx] && (m_shadow[idx] == data);
`endif
    chk("accept_ready", coeff_ready, 1);
    coeff_valid = 1'b1;
    coeff_data  = data;
    coeff_index = 2'(idx);
    dp_gnt      = 1'b0;
    tick();
    coeff_valid = 1'b0;
    m_last      = data;
    if (hit) begin
      check_idle("hit");
      return;
    end
    for (int t = 1; t <= d + 1 && t <= GT; t++) begin
      chk("req_dp_req", dp_req, 1);
      chk("req_ready",  coeff_ready, 0);
      chk("req_op",     op, OP_NOP);
      chk("req_dest",   dest, 0);
      dp_gnt       = (t - 1 >= d);
      clear_coeffs = clr_req && (t == 1);
      if (clr_req && t == 1) begin
        m_loaded = '0;
        m_err    = 1'b0;
      end
      tick();
    end
    clear_coeffs = 1'b0;
    if (d < GT) begin
      chk("iss_op",     op, OP_LOAD2);
      chk("iss_dest",   dest, BASE + idx);
      chk("iss_ext",    ext_coeff, data);
      chk("iss_dp_req", dp_req, 1);
      chk("iss_ready",  coeff_ready, 0);
      if (drop_gnt) dp_gnt = 1'b0;
      clear_coeffs = clr_iss;
      tick();
      clear_coeffs  = 1'b0;
      m_shadow[idx] = data;
      if (clr_iss) begin
        m_loaded = '0;
        m_err    = 1'b0;
      end else begin
        m_loaded[idx] = 1'b1;
      end
    end else begin
      m_err = 1'b1;
    end
    dp_gnt = 1'b0;
    check_idle("done");
  endtask

  initial begin
    int idx, d;
    logic [15:0] data;
    for (int i = 0; i < NC; i++) m_shadow[i] = '0;
    rst = 1'b1; coeff_valid = 1'b0; coeff_data = '0; coeff_index = '0;
    clear_coeffs = 1'b0; dp_gnt = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", coeff_ready, 0);
    chk("rst_dp_req", dp_req, 0);
    chk("rst_op", op, OP_NOP);
    chk("rst_dest", dest, 0);
    chk("rst_ext", ext_coeff, 0);
    chk("rst_loaded", coeff_loaded, 0);
    chk("rst_all", all_loaded, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", coeff_ready, 1);
    tick();

    // Single write, grant already high.
    do_write(2, 16'h1234, 0, 0, 0, 0);
    chk("first_loaded", coeff_loaded, 4'b0100);

    // All four slots, grant delayed 5 cycles each.
    for (int i = 0; i < NC; i++) do_write(i, 16'hA000 + 16'(i), 5, 0, 0, 0);
    chk("all_loaded_after4", all_loaded, 1);

    // Grant never comes: timeout sets err, mask unchanged.
    do_write(1, 16'hBEEF, 100, 0, 0, 0);
    chk("timeout_err", err, 1);
    chk("timeout_mask", coeff_loaded, 4'b1111);
    do_clear();
    chk("clear_err", err, 0);

    // Grant on the very last window cycle still issues.
    do_write(3, 16'h5A5A, GT - 1, 0, 0, 1);

    // Clear in the ISSUE cycle: op still issued, mask ends empty.
    do_write(1, 16'h0777, 2, 0, 1, 1);
    chk("clr_iss_mask", coeff_loaded, 4'b0000);

    // Grant held in IDLE is ignored.
    dp_gnt = 1'b1;
    tick();
    chk("idle_gnt_req", dp_req, 0);
    chk("idle_gnt_op", op, OP_NOP);
    dp_gnt = 1'b0;

`ifdef COEFF_SHADOW_EN
    do_write(0, 16'h00FF, 0, 0, 0, 0);
    do_write(0, 16'h00FF, 0, 0, 0, 0);
    chk("shadow_hit_req", dp_req, 0);
    do_write(0, 16'h0100, 0, 0, 0, 0);
`endif

    for (int n = 0; n < 40; n++) begin
      idx  = int'($urandom_range(0, NC - 1));
      data = ($urandom_range(0, 3) == 0) ? m_shadow[idx] : 16'($urandom);
      d    = int'($urandom_range(0, 10));
      do_write(idx, data, d, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
               $urandom_range(0, 1) == 1);
      if ($urandom_range(0, 9) == 0) do_clear();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
